dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Per-node data-memory responder: the memory end of a core's DMEM port (addr/d_out/memEn/memWrEn out, d_in back).
//  Serves loads with fixed 1-cycle latency and commits stores. Adds a post-reset clear sweep, a backdoor load port
//  for benches, and out-of-range detection. The CMP top instantiates one per node and holds cores until init_done.
// PARAMETERS
//  DATA_WIDTH  64   word width, matches core datapath
//  ADDR_WIDTH  32   core address bus width
//  DEPTH_LOG2  8    log2 words stored (256 words); word index = addr[DEPTH_LOG2-1:0]
// PORTS
//  clk          in   1           rising-edge clock
//  reset        in   1           asynchronous, active-low reset
//  memEn        in   1           core access valid this cycle
//  memWrEn      in   1           1 = store, 0 = load (qualified by memEn)
//  addr_in      in   ADDR_WIDTH  word address from core
//  wr_data      in   DATA_WIDTH  store data from core
//  rd_data      out  DATA_WIDTH  load data to core, registered
//  ld_en        in   1           backdoor write strobe
//  ld_addr      in   DEPTH_LOG2  backdoor word index
//  ld_data      in   DATA_WIDTH  backdoor write data
//  init_done    out  1           clear sweep finished, core port live
//  oor_err      out  1           1-cycle pulse: core access with addr_in[ADDR_WIDTH-1:DEPTH_LOG2] != 0
//  par_err      out  1           sticky parity error (DMEM_PARITY_EN only; else tied 0)
// BEHAVIOUR
//  Reset (reset=0, async): rd_data=0, init_done=0, oor_err=0, par_err=0, FSM->CLEAR, clr_ptr=0. Array not reset.
//  FSM CLEAR: writes 0 to word clr_ptr each cycle, clr_ptr++; after word 2^DEPTH_LOG2-1 -> READY (sweep = 2^DEPTH_LOG2 cycles).
//   init_done=1 registered on the cycle FSM enters READY. Core accesses during CLEAR ignored (rd_data stays 0).
//   Backdoor writes during CLEAR are accepted but may be overwritten by the sweep; benches load after init_done.
//  FSM READY: terminal until reset; reset mid-sweep restarts sweep from word 0.
//  Load: memEn=1,memWrEn=0 at edge N -> rd_data = mem[idx] at edge N+1 (valid cycle N+1). rd_data holds last value
//   when no load issued.
//  Store: memEn=1,memWrEn=1 -> mem[idx]<=wr_data at edge; rd_data unchanged. Load next cycle to same idx returns new data.
//  Out-of-range (upper addr bits nonzero): store dropped, load returns 0, oor_err=1 for one cycle following the access.
//  Backdoor: ld_en=1 writes mem[ld_addr]<=ld_data. Same-cycle core store to same word: backdoor wins.
//   Same-cycle core load to the word being backdoor-written returns OLD data (read-first).
//  memWrEn with memEn=0 ignored.
// CONFIGURATION
//  DMEM_PARITY_EN defined: each word stores an extra even-parity bit computed on every write (core, backdoor, sweep);
//   on each load the stored bit is checked; mismatch sets par_err, held until reset. Bench forces mismatch via
//   hierarchical force on the parity array.
//  Undefined: no parity storage, par_err tied 0; identical timing either way.
// STRUCTURE
//  Package dmem_pkg: dmem_state_e {ST_CLEAR, ST_READY}; DMEM_DATA_W=64, DMEM_DEPTH_LOG2=8 defaults shared with cmp top.
//  One sub-module: dmem_sram_1rw (sync array, 1 write port with backdoor-priority mux, 1 registered read port);
//   FSM, range check and parity logic live in dmem_responder.
// TESTING
//  1 Release reset, idle: init_done=0 for 256 cycles, =1 at cycle 256; load idx 0x2A after -> rd_data=0.
//  2 Store 0xDEADBEEF_01234567 to addr 5, next cycle load addr 5 -> rd_data=0xDEADBEEF_01234567 one cycle later.
//  3 Load addr 0x100 (DEPTH_LOG2=8) -> rd_data=0, oor_err pulses once; store 0x100 then load 0x00 -> 0 (not aliased).
//  4 Same cycle: ld_en to idx 7 =0xAA, core store idx 7 =0x55 -> later load idx 7 returns 0xAA.
//  5 Reset asserted at sweep cycle 100 (after backdoor wrote idx 200=0x1): re-release -> 256 more cycles, idx 200 reads 0.
//  6 DMEM_PARITY_EN: force parity bit of idx 3, load idx 3 -> par_err=1 and stays 1 over 10 clean loads until reset.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and default sizes for the per-node data-memory responder.
package dmem_pkg;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } dmem_state_e;

  localparam int DMEM_DATA_W     = 64;
  localparam int DMEM_ADDR_W     = 32;
  localparam int DMEM_DEPTH_LOG2 = 8;

endpackage

// File: rtl/dmem_if.sv
// Core-side DMEM port: the core is the master, the memory responder is the slave.
interface dmem_if import dmem_pkg::*; #(
  parameter int DATA_WIDTH = DMEM_DATA_W,
  parameter int ADDR_WIDTH = DMEM_ADDR_W
) ();

  logic                  memEn;
  logic                  memWrEn;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output memEn,
    output memWrEn,
    output addr_in,
    output wr_data,
    input  rd_data
  );

  modport slave (
    input  memEn,
    input  memWrEn,
    input  addr_in,
    input  wr_data,
    output rd_data
  );

endinterface

// File: rtl/dmem_sram_1rw.sv
// Synchronous word array: one write port (backdoor beats the primary writer) and one
// registered read port that reads the array before the same-edge write lands.
module dmem_sram_1rw #(
  parameter int WIDTH      = 64,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bd_we,
  input  logic [DEPTH_LOG2-1:0] bd_idx,
  input  logic [WIDTH-1:0]      bd_wdata,
  input  logic                  pri_we,
  input  logic [DEPTH_LOG2-1:0] pri_idx,
  input  logic [WIDTH-1:0]      pri_wdata,
  input  logic                  rd_en,
  input  logic                  rd_zero,
  input  logic [DEPTH_LOG2-1:0] rd_idx,
  output logic [WIDTH-1:0]      rd_word
);

  logic [WIDTH-1:0]      mem [0:(1<<DEPTH_LOG2)-1];
  logic                  we;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [WIDTH-1:0]      w_data;
  logic [WIDTH-1:0]      rd_word_d;
  logic [WIDTH-1:0]      rd_word_q;

  always_comb begin
    we     = bd_we | pri_we;
    w_idx  = bd_we ? bd_idx   : pri_idx;
    w_data = bd_we ? bd_wdata : pri_wdata;
  end

  // The array itself is never reset; the clear sweep upstream initialises it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[w_idx] <= w_data;
    end
  end

  always_comb begin
    rd_word_d = rd_word_q;
    if (rd_en) begin
      rd_word_d = rd_zero ? '0 : mem[rd_idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_word_q <= '0;
    end else begin
      rd_word_q <= rd_word_d;
    end
  end

  assign rd_word = rd_word_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory end of a core DMEM port: post-reset clear sweep, 1-cycle loads, stores, backdoor
// load port and out-of-range detection. Optional parity checking under `DMEM_PARITY_EN.
module dmem_responder import dmem_pkg::*; #(
  parameter int DATA_WIDTH = DMEM_DATA_W,
  parameter int ADDR_WIDTH = DMEM_ADDR_W,
  parameter int DEPTH_LOG2 = DMEM_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  reset,
  dmem_if.slave                 core,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  init_done,
  output logic                  oor_err,
  output logic                  par_err
);

`ifdef DMEM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int WORD_W = DATA_WIDTH + PAR_W;
  localparam logic [DEPTH_LOG2-1:0] LAST_IDX = '1;

  dmem_state_e           state_q, state_d;
  logic [DEPTH_LOG2-1:0] clr_ptr_q, clr_ptr_d;
  logic                  init_done_q, init_done_d;
  logic                  oor_err_q, oor_err_d;

  logic [DEPTH_LOG2-1:0] core_idx;
  logic                  core_oor;
  logic                  access;
  logic                  ld_req;
  logic                  st_req;
  logic                  pri_we;
  logic [DEPTH_LOG2-1:0] pri_idx;
  logic [DATA_WIDTH-1:0] pri_data;
  logic [WORD_W-1:0]     bd_word;
  logic [WORD_W-1:0]     pri_word;
  logic [WORD_W-1:0]     rd_word;

  assign core_idx = core.addr_in[DEPTH_LOG2-1:0];
  assign core_oor = |core.addr_in[ADDR_WIDTH-1:DEPTH_LOG2];
  assign access   = (state_q == ST_READY) && core.memEn;
  assign ld_req   = access && !core.memWrEn;
  assign st_req   = access && core.memWrEn && !core_oor;

  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    init_done_d = init_done_q;
    oor_err_d   = access && core_oor;
    case (state_q)
      ST_CLEAR: begin
        clr_ptr_d = clr_ptr_q + DEPTH_LOG2'(1);
        if (clr_ptr_q == LAST_IDX) begin
          state_d     = ST_READY;
          init_done_d = 1'b1;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_CLEAR;
      clr_ptr_q   <= '0;
      init_done_q <= 1'b0;
      oor_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      init_done_q <= init_done_d;
      oor_err_q   <= oor_err_d;
    end
  end

  // The sweep owns the primary write port until READY; afterwards core stores use it.
  always_comb begin
    pri_we   = 1'b0;
    pri_idx  = core_idx;
    pri_data = core.wr_data;
    if (state_q == ST_CLEAR) begin
      pri_we   = 1'b1;
      pri_idx  = clr_ptr_q;
      pri_data = '0;
    end else if (st_req) begin
      pri_we   = 1'b1;
    end
  end

`ifdef DMEM_PARITY_EN
  logic par_chk_q;
  logic par_err_q, par_err_d;

  assign bd_word  = {^ld_data, ld_data};
  assign pri_word = {^pri_data, pri_data};

  // Even parity over data plus stored bit, checked on the word a load just returned.
  always_comb begin
    par_err_d = par_err_q | (par_chk_q & (^rd_word));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_chk_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      par_chk_q <= ld_req;
      par_err_q <= par_err_d;
    end
  end

  assign par_err = par_err_q;
`else
  assign bd_word  = ld_data;
  assign pri_word = pri_data;
  assign par_err  = 1'b0;
`endif

  dmem_sram_1rw #(
    .WIDTH      (WORD_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_sram (
    .clk       (clk),
    .reset     (reset),
    .bd_we     (ld_en),
    .bd_idx    (ld_addr),
    .bd_wdata  (bd_word),
    .pri_we    (pri_we),
    .pri_idx   (pri_idx),
    .pri_wdata (pri_word),
    .rd_en     (ld_req),
    .rd_zero   (core_oor),
    .rd_idx    (core_idx),
    .rd_word   (rd_word)
  );

  assign core.rd_data = rd_word[DATA_WIDTH-1:0];
  assign init_done    = init_done_q;
  assign oor_err      = oor_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: stimulus pushes expected rd_data/oor_err per core
// access, a monitor pops and compares after each access edge.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int DW = 64;
  localparam int AW = 32;
  localparam int DL = 8;

  typedef struct {
    logic [DW-1:0] data;
    logic          oor;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ld_en;
  logic [DL-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          init_done;
  logic          oor_err;
  logic          par_err;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_fail = 0;
  logic [DW-1:0] last_rd = '0;

  always #5 clk = ~clk;

  dmem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  dmem_responder #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH_LOG2 (DL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .core      (bus.slave),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .init_done (init_done),
    .oor_err   (oor_err),
    .par_err   (par_err)
  );

  task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one core access for exactly one rising edge, starting just after a falling edge.
  task automatic apply_stimulus(input logic we, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input logic [DW-1:0] exp_data);
    exp_t e;
    bus.memEn   = 1'b1;
    bus.memWrEn = we;
    bus.addr_in = addr;
    bus.wr_data = wdata;
    if (!we) last_rd = exp_data;
    e.data = last_rd;
    e.oor  = |addr[AW-1:DL];
    sb.push_back(e);
    @(negedge clk);
    bus.memEn   = 1'b0;
    bus.memWrEn = 1'b0;
  endtask

  task automatic do_load(input logic [AW-1:0] addr, input logic [DW-1:0] exp_data);
    apply_stimulus(1'b0, addr, '0, exp_data);
  endtask

  task automatic do_store(input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    apply_stimulus(1'b1, addr, wdata, '0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    last_rd = '0;
    check_output("rst_rd_data", bus.rd_data, '0);
    check_output("rst_init_done", {63'd0, init_done}, '0);
    check_output("rst_oor_err", {63'd0, oor_err}, '0);
    check_output("rst_par_err", {63'd0, par_err}, '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // init_done must rise exactly on the 256th edge after reset release.
  task automatic run_sweep(input int first, input int last);
    for (int k = first; k <= last; k++) begin
      @(negedge clk);
      check_output("sweep_init_done", {63'd0, init_done}, {63'd0, (k == 256)});
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      if (bus.memEn) begin
        #1;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL sb_underflow: got access with empty queue, expected queued entry");
        end else begin
          e = sb.pop_front();
          check_output("rd_data", bus.rd_data, e.data);
          check_output("oor_err", {63'd0, oor_err}, {63'd0, e.oor});
        end
      end else begin
        #1;
        check_output("oor_idle", {63'd0, oor_err}, '0);
      end
    end
  end

  initial begin : watchdog
    #200000;
    n_fail++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : stimulus
    bus.memEn   = 1'b0;
    bus.memWrEn = 1'b0;
    bus.addr_in = '0;
    bus.wr_data = '0;
    ld_en       = 1'b0;
    ld_addr     = '0;
    ld_data     = '0;
    #2;
    $display("[TB] reset and clear sweep");
    do_reset();
    run_sweep(1, 256);
    do_load(32'h2A, 64'h0);

    $display("[TB] store then load");
    do_store(32'h5, 64'hDEADBEEF_01234567);
    do_load(32'h5, 64'hDEADBEEF_01234567);
    do_store(32'hFF, 64'h0123_4567_89AB_CDEF);
    do_load(32'hFF, 64'h0123_4567_89AB_CDEF);

    $display("[TB] out-of-range accesses");
    do_load(32'h100, 64'h0);
    idle(1);
    do_store(32'h100, 64'h1234);
    do_load(32'h0, 64'h0);
    do_store(32'h8000_0005, 64'hFFFF);
    do_load(32'h5, 64'hDEADBEEF_01234567);

    $display("[TB] backdoor priority and read-first");
    ld_en = 1'b1; ld_addr = 8'd7; ld_data = 64'hAA;
    do_store(32'h7, 64'h55);
    ld_en = 1'b0;
    do_load(32'h7, 64'hAA);
    ld_en = 1'b1; ld_addr = 8'd9; ld_data = 64'h99;
    do_load(32'h9, 64'h0);
    ld_en = 1'b0;
    do_load(32'h9, 64'h99);

    $display("[TB] memWrEn without memEn");
    bus.memWrEn = 1'b1; bus.addr_in = 32'h8; bus.wr_data = 64'h77;
    @(negedge clk);
    bus.memWrEn = 1'b0;
    do_load(32'h8, 64'h0);

    $display("[TB] reset mid-sweep");
    do_reset();
    run_sweep(1, 50);
    ld_en = 1'b1; ld_addr = 8'd200; ld_data = 64'h1;
    run_sweep(51, 51);
    ld_en = 1'b0;
    run_sweep(52, 100);
    do_reset();
    run_sweep(1, 256);
    do_load(32'd200, 64'h0);

`ifdef DMEM_PARITY_EN
    $display("[TB] parity error");
    force dut.u_sram.mem[3][DW] = 1'b1;
    do_load(32'h3, 64'h0);
    idle(1);
    check_output("par_err_set", {63'd0, par_err}, 64'h1);
    repeat (10) do_load(32'h9, 64'h0);
    check_output("par_err_sticky", {63'd0, par_err}, 64'h1);
    release dut.u_sram.mem[3][DW];
    do_reset();
    run_sweep(1, 256);
`endif

    idle(2);
    check_output("par_err_final", {63'd0, par_err}, '0);
    check_output("sb_empty", 64'(sb.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
